// File: rtl/list_sum_pkg.sv
// rtl/list_sum_pkg.sv - shared FSM encoding and default sizes for the list-sum engine
package list_sum_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_MAX_NODES = 1024;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH_NEXT = 3'd1,
        FETCH_VAL  = 3'd2,
        ACCUM      = 3'd3,
        DONE       = 3'd4
    } state_t;

endpackage

// File: rtl/list_sum_adder.sv
// rtl/list_sum_adder.sv - accumulator adder; LIST_SUM_SATURATE_EN selects clamp instead of wrap
module list_sum_adder
    import list_sum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sat_in,
    output logic [DATA_W-1:0] s,
    output logic              carry
);

    logic [DATA_W:0] raw;

    assign raw   = {1'b0, a} + {1'b0, b};
    assign carry = raw[DATA_W];

`ifdef LIST_SUM_SATURATE_EN
    // Once the walk has overflowed the sum stays pinned at the maximum.
    assign s = (carry || sat_in) ? '1 : raw[DATA_W-1:0];
`else
    logic unused_sat;
    assign unused_sat = sat_in;
    assign s = raw[DATA_W-1:0];
`endif

endmodule

// File: rtl/list_sum_engine.sv
// rtl/list_sum_engine.sv - linked-list walker/accumulator (optional LIST_SUM_SATURATE_EN)
module list_sum_engine
    import list_sum_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MAX_NODES = DEF_MAX_NODES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] head_addr,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] sum,
    output logic [CNT_W-1:0]  node_count,
    output logic              overflow,
    output logic              err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_NODES);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] next_r;
    logic [CNT_W-1:0]  count_inc;
    logic              last_node;
    logic              limit_hit;
    logic [DATA_W-1:0] add_s;
    logic              add_c;

    assign count_inc = node_count + CNT_W'(1);
    assign last_node = (next_r == '0);
    assign limit_hit = (count_inc == MAX_CNT);

    list_sum_adder #(.DATA_W(DATA_W)) u_adder (
        .a      (sum),
        .b      (ram_rdata),
        .sat_in (overflow),
        .s      (add_s),
        .carry  (add_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: three cycles per node, empty list goes straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (start) state_nxt = (head_addr == '0) ? DONE : FETCH_NEXT;
            FETCH_NEXT: state_nxt = FETCH_VAL;
            FETCH_VAL:  state_nxt = ACCUM;
            ACCUM:      state_nxt = (last_node || limit_hit) ? DONE : FETCH_NEXT;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state: RAM address mux, busy and done.
    always_comb begin
        ram_addr = '0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            FETCH_NEXT: begin
                ram_addr = ptr;
                busy     = 1'b1;
            end
            FETCH_VAL: begin
                ram_addr = ptr + ADDR_W'(1);
                busy     = 1'b1;
            end
            ACCUM:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: pointer, captured next link, running sum, count and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            next_r     <= '0;
            sum        <= '0;
            node_count <= '0;
            overflow   <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr        <= head_addr;
                        sum        <= '0;
                        node_count <= '0;
                        overflow   <= 1'b0;
                        err        <= 1'b0;
                    end
                end
                FETCH_VAL: next_r <= ram_rdata[ADDR_W-1:0];
                ACCUM: begin
                    sum        <= add_s;
                    node_count <= count_inc;
                    overflow   <= overflow | add_c;
                    if (!last_node && limit_hit) err <= 1'b1;
                    if (!last_node && !limit_hit) ptr <= next_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_list_sum_engine.sv
// tb/tb_list_sum_engine.sv - scoreboard bench for list_sum_engine with a list-walking reference model
module tb_list_sum_engine;

    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int CW   = 16;
    localparam int MAXN = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] head_addr = '0;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rdata = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] sum;
    logic [CW-1:0] node_count;
    logic          overflow;
    logic          err;

    logic [DW-1:0] mem [256];
    int            cycnt = 0;
    int            tests = 0;
    int            fails = 0;

    typedef struct {
        logic [7:0] sum;
        int         cnt;
        logic       ovf;
        logic       err;
        int         lat;
        int         t0;
    } exp_t;

    exp_t sb[$];

    list_sum_engine #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .MAX_NODES(MAXN)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .head_addr  (head_addr),
        .ram_addr   (ram_addr),
        .ram_rdata  (ram_rdata),
        .busy       (busy),
        .done       (done),
        .sum        (sum),
        .node_count (node_count),
        .overflow   (overflow),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycnt     <= cycnt + 1;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: follow the list through the memory array with plain integers.
    function automatic exp_t model(input logic [7:0] head);
        exp_t       e;
        int         s;
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] nxt;
        s = 0;
        p = head;
        e.cnt = 0; e.ovf = 1'b0; e.err = 1'b0; e.t0 = 0;
        if (head == 8'd0) begin
            e.sum = 8'd0;
            e.lat = 1;
            return e;
        end
        for (int k = 0; k < 1000; k++) begin
            q   = p + 8'd1;
            nxt = mem[p];
            s   = s + int'(mem[q]);
            if (s > 255) e.ovf = 1'b1;
`ifdef LIST_SUM_SATURATE_EN
            if (e.ovf) s = 255;
`else
            s = s % 256;
`endif
            e.cnt++;
            if (nxt == 8'd0) break;
            if (e.cnt == MAXN) begin
                e.err = 1'b1;
                break;
            end
            p = nxt;
        end
        e.sum = s[7:0];
        e.lat = 3 * e.cnt + 1;
        return e;
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cycnt);
            end else begin
                e = sb.pop_front();
                check("sum",        int'(sum),        int'(e.sum));
                check("node_count", int'(node_count), e.cnt);
                check("overflow",   int'(overflow),   int'(e.ovf));
                check("err",        int'(err),        int'(e.err));
                check("latency",    cycnt - e.t0,     e.lat);
                check("busy_at_done", int'(busy),     0);
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic launch(input logic [7:0] head);
        exp_t e;
        e = model(head);
        @(negedge clk);
        e.t0      = cycnt;
        start     = 1'b1;
        head_addr = head;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic load_three();
        clear_mem();
        mem[4]  = 8'd10; mem[5]  = 8'd7;
        mem[10] = 8'd20; mem[11] = 8'd5;
        mem[20] = 8'd0;  mem[21] = 8'd100;
    endtask

    initial begin
        logic [7:0] slots [127];
        logic [7:0] tmp;
        int         n;
        int         j;

        clear_mem();
        repeat (3) @(negedge clk);
        check("rst_ram_addr",   int'(ram_addr),   0);
        check("rst_busy",       int'(busy),       0);
        check("rst_done",       int'(done),       0);
        check("rst_sum",        int'(sum),        0);
        check("rst_node_count", int'(node_count), 0);
        check("rst_overflow",   int'(overflow),   0);
        check("rst_err",        int'(err),        0);
        rst = 1'b0;

        // Three-node list: sum 112, done in cycle 10.
        load_three();
        launch(8'd4);
        wait_idle();

        // Empty list: done in cycle 1 and busy never rises.
        launch(8'd0);
        for (int i = 0; i < 3; i++) begin
            check("empty_busy", int'(busy), 0);
            @(negedge clk);
        end
        wait_idle();

        // 200 + 100 overflows an 8-bit sum.
        clear_mem();
        mem[4] = 8'd6; mem[5] = 8'd200;
        mem[6] = 8'd0; mem[7] = 8'd100;
        launch(8'd4);
        wait_idle();

        // Self-loop runs into the node limit.
        clear_mem();
        mem[4] = 8'd4; mem[5] = 8'd1;
        launch(8'd4);
        wait_idle();

        // Value address p+1 wraps to 0.
        clear_mem();
        mem[255] = 8'd0; mem[0] = 8'd9;
        launch(8'd255);
        wait_idle();

        // Reset in cycle 5 of a walk, then a clean rerun.
        load_three();
        launch(8'd4);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midrst_busy",       int'(busy),       0);
        check("midrst_sum",        int'(sum),        0);
        check("midrst_node_count", int'(node_count), 0);
        rst = 1'b0;
        launch(8'd4);
        wait_idle();

        // Start pulses in cycles 2 and 10 of a walk are ignored.
        load_three();
        launch(8'd4);
        @(negedge clk);
        start = 1'b1; head_addr = 8'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        start = 1'b1; head_addr = 8'd4;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (15) @(negedge clk);

        // Random lists, some closed into loops.
        for (int t = 0; t < 24; t++) begin
            clear_mem();
            for (int i = 0; i < 127; i++) slots[i] = 8'(2 * (i + 1));
            for (int i = 126; i > 0; i--) begin
                j = int'($urandom_range(0, i));
                tmp = slots[i]; slots[i] = slots[j]; slots[j] = tmp;
            end
            n = int'($urandom_range(1, 20));
            for (int i = 0; i < n; i++) begin
                mem[slots[i]]        = (i == n - 1) ? 8'd0 : slots[i + 1];
                mem[slots[i] + 8'd1] = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 3) == 0) mem[slots[n - 1]] = slots[0];
            launch(slots[0]);
            wait_idle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
